// File: rtl/tdot_feeder_if.sv
// Element stream into the dot-product feeder: one (a, b, c) beat per
// valid/ready handshake. c is only meaningful on the first beat of a vector.
interface tdot_feeder_if #(
    parameter int W = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] in_c;

    modport master (output in_valid, output in_a, output in_b, output in_c, input in_ready);
    modport slave  (input in_valid, input in_a, input in_b, input in_c, output in_ready);
endinterface

// File: rtl/tdot_feeder.sv
// Operand feeder for the 3-slice cascaded DSP dot-product unit.
// Gathers a 3-element vector from the element stream, presents it to the
// cascade with a 0/1/2-cycle lane skew, and captures the unit's result
// DOT_LAT cycles after lane 0 was presented. Also holds off the stream for
// RST_HOLD cycles after reset so the DSP slices can settle.
module tdot_feeder #(
    parameter int W        = 8,
    parameter int N        = 3,
    parameter int RST_HOLD = 3,
    parameter int DOT_LAT  = 5
) (
    input  logic         clk,
    input  logic         reset,
    tdot_feeder_if.slave in_if,
    output logic [W-1:0] a0,
    output logic [W-1:0] a1,
    output logic [W-1:0] a2,
    output logic [W-1:0] b0,
    output logic [W-1:0] b1,
    output logic [W-1:0] b2,
    output logic [W-1:0] c,
    input  logic [W-1:0] y_in,
    output logic [W-1:0] y_data,
    output logic         y_valid,
    output logic         busy
);

    // RST_HOLD is expected to be at least 1.
    localparam int HW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {
        E0 = 2'd0,
        E1 = 2'd1,
        E2 = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hold_q;
    logic          accept;
    logic          issue_d;
    logic          issue_q;
    logic [W-1:0]  slot_a [N];
    logic [W-1:0]  slot_b [N];
    logic [W-1:0]  c_slot;
    logic [W-1:0]  dly_a1;
    logic [W-1:0]  dly_b1;
    logic [W-1:0]  dly_a2;
    logic [W-1:0]  dly_b2;
    // Bit k marks a vector whose lane 0 was presented k cycles ago; the top
    // bit lines up with the cycle in which y_in carries that vector's result.
    logic [DOT_LAT:0] trk_q;

    assign in_if.in_ready = !reset && (hold_q == '0);
    assign accept         = in_if.in_valid && in_if.in_ready;

    // A pending issue (issue_q) counts as in flight so busy has no gap
    // between the last beat and lane 0 appearing.
    assign busy = !reset && ((state_q != E0) || issue_q || (|trk_q) || y_valid);

    // Post-reset hold window: count down to zero, then open the stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= HW'(RST_HOLD);
        end else if (hold_q != '0) begin
            hold_q <= hold_q - HW'(1);
        end
    end

    // Gather FSM next state: advance one element slot per accepted beat.
    always_comb begin
        state_d = state_q;
        issue_d = 1'b0;
        if (accept) begin
            case (state_q)
                E0: state_d = E1;
                E1: state_d = E2;
                E2: begin
                    state_d = E0;
                    issue_d = 1'b1;
                end
                default: state_d = E0;
            endcase
        end
    end

    // Gather FSM state register and the one-cycle issue strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= E0;
            issue_q <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
        end
    end

    // Gather buffer: the slot selected by the current index takes the beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                slot_a[i] <= '0;
                slot_b[i] <= '0;
            end
            c_slot <= '0;
        end else if (accept) begin
            case (state_q)
                E0: begin
                    slot_a[0] <= in_if.in_a;
                    slot_b[0] <= in_if.in_b;
                    c_slot    <= in_if.in_c;
                end
                E1: begin
                    slot_a[1] <= in_if.in_a;
                    slot_b[1] <= in_if.in_b;
                end
                E2: begin
                    slot_a[2] <= in_if.in_a;
                    slot_b[2] <= in_if.in_b;
                end
                default: ;
            endcase
        end
    end

    // Lane 0 and bias go out at issue; slots 1/2 move to private delay
    // registers so the gather buffer is free for the next vector at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            a0     <= '0;
            b0     <= '0;
            c      <= '0;
            dly_a1 <= '0;
            dly_b1 <= '0;
            dly_a2 <= '0;
            dly_b2 <= '0;
        end else begin
            a0 <= issue_q ? slot_a[0] : '0;
            b0 <= issue_q ? slot_b[0] : '0;
            c  <= issue_q ? c_slot    : '0;
            if (issue_q) begin
                dly_a1 <= slot_a[1];
                dly_b1 <= slot_b[1];
                dly_a2 <= slot_a[2];
                dly_b2 <= slot_b[2];
            end
        end
    end

    // Lanes 1 and 2 follow lane 0 by one and two cycles, zero otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            a1 <= '0;
            b1 <= '0;
            a2 <= '0;
            b2 <= '0;
        end else begin
            a1 <= trk_q[0] ? dly_a1 : '0;
            b1 <= trk_q[0] ? dly_b1 : '0;
            a2 <= trk_q[1] ? dly_a2 : '0;
            b2 <= trk_q[1] ? dly_b2 : '0;
        end
    end

    // In-flight tracker and result capture, one pulse per issued vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            trk_q   <= '0;
            y_data  <= '0;
            y_valid <= 1'b0;
        end else begin
            trk_q   <= {trk_q[DOT_LAT-1:0], issue_q};
            y_valid <= trk_q[DOT_LAT];
            if (trk_q[DOT_LAT]) begin
                y_data <= y_in;
            end
        end
    end

endmodule

// File: tb/tb_tdot_feeder.sv
// Self-checking bench for tdot_feeder. A behavioural cascade model supplies
// y_in; a schedule-based reference model predicts in_ready, lane contents
// and result pulses for every cycle.
module tb_tdot_feeder;

    localparam int W        = 8;
    localparam int RST_HOLD = 3;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a0, a1, a2, b0, b1, b2, c, y_in, y_data;
    logic       y_valid, busy;
    logic [55:0] got_l;

    tdot_feeder_if #(.W(W)) s_if ();

    tdot_feeder #(.W(W), .N(3), .RST_HOLD(RST_HOLD), .DOT_LAT(5)) dut (
        .clk(clk), .reset(reset), .in_if(s_if),
        .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2), .c(c),
        .y_in(y_in), .y_data(y_data), .y_valid(y_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    assign got_l = {a0, a1, a2, b0, b1, b2, c};

    // Cascade model: each lane's product lands 5, 4 and 3 cycles later.
    logic [23:0] h0 [0:4] = '{default: '0};
    logic [15:0] h1 [0:3] = '{default: '0};
    logic [15:0] h2 [0:2] = '{default: '0};

    always @(posedge clk) begin
        h0[0] <= {a0, b0, c};
        h1[0] <= {a1, b1};
        h2[0] <= {a2, b2};
        for (int i = 1; i < 5; i++) h0[i] <= h0[i-1];
        for (int i = 1; i < 4; i++) h1[i] <= h1[i-1];
        for (int i = 1; i < 3; i++) h2[i] <= h2[i-1];
    end

    assign y_in = 8'(h0[4][23:16] * h0[4][15:8] + h0[4][7:0]
                   + h1[3][15:8] * h1[3][7:0] + h2[2][15:8] * h2[2][7:0]);

    int n_vec = 0;
    int n_err = 0;
    int k = 0;
    int rel = -1;
    bit cur_rst, cur_v;
    beat_t cur_bt;
    int m_idx = 0;
    logic [7:0] m_a [3];
    logic [7:0] m_b [3];
    logic [7:0] m_c;
    logic [23:0] e_l0 [int];
    logic [15:0] e_l1 [int];
    logic [15:0] e_l2 [int];
    logic [7:0]  e_y [int];
    logic        exp_ready;
    logic [55:0] exp_l;
    logic        exp_yv;
    logic [7:0]  exp_yd;

    function automatic beat_t mk(input int a, input int b, input int cc);
        return beat_t'{8'(a), 8'(b), 8'(cc)};
    endfunction

    // Apply inputs for the current cycle and compute the expected outputs.
    task automatic drive(input bit rst, input bit v, input beat_t bt);
        logic [23:0] l0;
        logic [15:0] l1, l2;
        cur_rst = rst; cur_v = v; cur_bt = bt;
        reset = rst;
        s_if.in_valid = v;
        s_if.in_a = bt.a; s_if.in_b = bt.b; s_if.in_c = bt.c;
        if (rst) rel = -1;
        else if (rel < 0) rel = k;
        #1;
        exp_ready = !rst && (rel >= 0) && (k >= rel + RST_HOLD);
        l0 = e_l0.exists(k) ? e_l0[k] : 24'h0;
        l1 = e_l1.exists(k) ? e_l1[k] : 16'h0;
        l2 = e_l2.exists(k) ? e_l2[k] : 16'h0;
        exp_l  = {l0[23:16], l1[15:8], l2[15:8], l0[15:8], l1[7:0], l2[7:0], l0[7:0]};
        exp_yv = e_y.exists(k);
        exp_yd = exp_yv ? e_y[k] : 8'h00;
    endtask

    // Update the reference model for this cycle's reset/acceptance, then clock.
    task automatic advance();
        int s, sum;
        if (cur_rst) begin
            e_l0.delete(); e_l1.delete(); e_l2.delete(); e_y.delete();
            m_idx = 0;
        end else if (exp_ready && cur_v) begin
            if (m_idx == 0) m_c = cur_bt.c;
            m_a[m_idx] = cur_bt.a;
            m_b[m_idx] = cur_bt.b;
            if (m_idx == 2) begin
                s = k + 2;
                e_l0[s]   = {m_a[0], m_b[0], m_c};
                e_l1[s+1] = {m_a[1], m_b[1]};
                e_l2[s+2] = {m_a[2], m_b[2]};
                sum = int'(m_a[0]) * int'(m_b[0]) + int'(m_a[1]) * int'(m_b[1])
                    + int'(m_a[2]) * int'(m_b[2]) + int'(m_c);
                e_y[s+6] = 8'(sum);
            end
            m_idx = (m_idx + 1) % 3;
        end
        @(posedge clk);
        k++;
        #1;
    endtask

    task automatic test_reset();
        beat_t q[$];
        beat_t bt;
        int first_rdy = -1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, mk(9, 9, 9));
            n_vec++;
            if ({got_l, y_valid, y_data, busy, s_if.in_ready} !== '0) begin
                n_err++;
                $display("[TB] FAIL reset.zero cyc=%0d lanes=%h yv=%b yd=%0d busy=%b rdy=%b required all 0",
                         k, got_l, y_valid, y_data, busy, s_if.in_ready);
            end
            advance();
        end
        q.push_back(mk(3, 1, 9)); q.push_back(mk(5, 2, 0)); q.push_back(mk(7, 4, 0));
        for (int i = 0; i < 16; i++) begin
            bt = '0;
            if (q.size() > 0) bt = q[0];
            drive(1'b0, q.size() > 0, bt);
            n_vec += 3;
            if (s_if.in_ready !== exp_ready) begin
                n_err++; $display("[TB] FAIL reset.ready cyc=%0d got=%b exp=%b", k, s_if.in_ready, exp_ready);
            end
            if (got_l !== exp_l) begin
                n_err++; $display("[TB] FAIL reset.lanes cyc=%0d got=%h exp=%h", k, got_l, exp_l);
            end
            if ({y_valid, exp_yv ? y_data : 8'h00} !== {exp_yv, exp_yd}) begin
                n_err++; $display("[TB] FAIL reset.result cyc=%0d got=%b/%0d exp=%b/%0d", k, y_valid, y_data, exp_yv, exp_yd);
            end
            if (first_rdy < 0 && s_if.in_ready === 1'b1) first_rdy = k - rel;
            if (exp_ready && cur_v) void'(q.pop_front());
            advance();
        end
        n_vec++;
        if (first_rdy != 3) begin
            n_err++; $display("[TB] FAIL reset.hold first ready offset got=%0d exp=3", first_rdy);
        end
    endtask

    task automatic test_basic(input bit wrap);
        beat_t q[$];
        beat_t bt;
        int pulses = 0;
        logic [7:0] last_y = '0;
        logic [7:0] want;
        if (wrap) begin
            q.push_back(mk(255, 255, 255)); q.push_back(mk(255, 255, 0)); q.push_back(mk(255, 255, 17));
            want = 8'd2;
        end else begin
            q.push_back(mk(1, 4, 7)); q.push_back(mk(2, 5, int'($urandom_range(255))));
            q.push_back(mk(3, 6, int'($urandom_range(255))));
            want = 8'd39;
        end
        for (int i = 0; i < 16; i++) begin
            bt = '0;
            if (q.size() > 0) bt = q[0];
            drive(1'b0, q.size() > 0, bt);
            n_vec += 3;
            if (s_if.in_ready !== exp_ready) begin
                n_err++; $display("[TB] FAIL basic.ready cyc=%0d got=%b exp=%b", k, s_if.in_ready, exp_ready);
            end
            if (got_l !== exp_l) begin
                n_err++; $display("[TB] FAIL basic.lanes cyc=%0d got=%h exp=%h", k, got_l, exp_l);
            end
            if ({y_valid, exp_yv ? y_data : 8'h00} !== {exp_yv, exp_yd}) begin
                n_err++; $display("[TB] FAIL basic.result cyc=%0d got=%b/%0d exp=%b/%0d", k, y_valid, y_data, exp_yv, exp_yd);
            end
            if (y_valid === 1'b1) begin pulses++; last_y = y_data; end
            if (exp_ready && cur_v) void'(q.pop_front());
            advance();
        end
        n_vec += 2;
        if (pulses != 1) begin
            n_err++; $display("[TB] FAIL basic.pulses wrap=%0d got=%0d exp=1", wrap, pulses);
        end
        if (last_y !== want) begin
            n_err++; $display("[TB] FAIL basic.value wrap=%0d got=%0d exp=%0d", wrap, last_y, want);
        end
    endtask

    task automatic test_gaps();
        beat_t q[$];
        beat_t bt;
        int pulses = 0;
        logic [7:0] last_y = '0;
        q.push_back(mk(1, 4, 7)); q.push_back(mk(2, 5, 99)); q.push_back(mk(3, 6, 42));
        for (int i = 0; i < 20; i++) begin
            bt = '0;
            if (q.size() > 0) bt = q[0];
            drive(1'b0, (q.size() > 0) && (i % 3 == 0), bt);
            n_vec += 3;
            if (s_if.in_ready !== exp_ready) begin
                n_err++; $display("[TB] FAIL gaps.ready cyc=%0d got=%b exp=%b", k, s_if.in_ready, exp_ready);
            end
            if (got_l !== exp_l) begin
                n_err++; $display("[TB] FAIL gaps.lanes cyc=%0d got=%h exp=%h", k, got_l, exp_l);
            end
            if ({y_valid, exp_yv ? y_data : 8'h00} !== {exp_yv, exp_yd}) begin
                n_err++; $display("[TB] FAIL gaps.result cyc=%0d got=%b/%0d exp=%b/%0d", k, y_valid, y_data, exp_yv, exp_yd);
            end
            if (y_valid === 1'b1) begin pulses++; last_y = y_data; end
            if (exp_ready && cur_v) void'(q.pop_front());
            advance();
        end
        n_vec += 2;
        if (pulses != 1) begin
            n_err++; $display("[TB] FAIL gaps.pulses got=%0d exp=1", pulses);
        end
        if (last_y !== 8'd39) begin
            n_err++; $display("[TB] FAIL gaps.value got=%0d exp=39", last_y);
        end
    endtask

    task automatic test_back_to_back();
        beat_t q[$];
        beat_t bt;
        int ys[$];
        int pk[$];
        int lastp = -100;
        bit busy_seen = 0;
        for (int v = 0; v < 4; v++) begin
            q.push_back(mk(1, 1, v));
            q.push_back(mk(1, 1, int'($urandom_range(255))));
            q.push_back(mk(1, 1, int'($urandom_range(255))));
        end
        for (int i = 0; i < 26; i++) begin
            bt = '0;
            if (q.size() > 0) bt = q[0];
            drive(1'b0, q.size() > 0, bt);
            n_vec += 3;
            if (s_if.in_ready !== exp_ready) begin
                n_err++; $display("[TB] FAIL stream.ready cyc=%0d got=%b exp=%b", k, s_if.in_ready, exp_ready);
            end
            if (got_l !== exp_l) begin
                n_err++; $display("[TB] FAIL stream.lanes cyc=%0d got=%h exp=%h", k, got_l, exp_l);
            end
            if ({y_valid, exp_yv ? y_data : 8'h00} !== {exp_yv, exp_yd}) begin
                n_err++; $display("[TB] FAIL stream.result cyc=%0d got=%b/%0d exp=%b/%0d", k, y_valid, y_data, exp_yv, exp_yd);
            end
            if (k == lastp + 1 && ys.size() == 4) begin
                busy_seen = 1;
                n_vec++;
                if (busy !== 1'b0) begin
                    n_err++; $display("[TB] FAIL stream.busy cyc=%0d got=%b exp=0", k, busy);
                end
            end
            if (y_valid === 1'b1) begin ys.push_back(int'(y_data)); pk.push_back(k); lastp = k; end
            if (exp_ready && cur_v) void'(q.pop_front());
            advance();
        end
        n_vec += 2;
        if (ys.size() != 4) begin
            n_err++; $display("[TB] FAIL stream.count got=%0d exp=4", ys.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                n_vec++;
                if (ys[j] != 3 + j) begin
                    n_err++; $display("[TB] FAIL stream.value idx=%0d got=%0d exp=%0d", j, ys[j], 3 + j);
                end
                if (j > 0 && pk[j] - pk[j-1] != 3) begin
                    n_err++; $display("[TB] FAIL stream.spacing idx=%0d got=%0d exp=3", j, pk[j] - pk[j-1]);
                end
            end
        end
        if (!busy_seen) begin
            n_err++; $display("[TB] FAIL stream.busy_window got=not reached exp=reached");
        end
    endtask

    task automatic test_reset_mid();
        beat_t q[$];
        beat_t bt;
        bit rst;
        int pulses = 0;
        logic [7:0] last_y = '0;
        q.push_back(mk(1, 4, 7)); q.push_back(mk(2, 5, 0)); q.push_back(mk(3, 6, 0));
        q.push_back(mk(9, 9, 9)); q.push_back(mk(8, 8, 0));
        q.push_back(mk(1, 4, 7)); q.push_back(mk(2, 5, 50)); q.push_back(mk(3, 6, 60));
        for (int i = 0; i < 28; i++) begin
            rst = (i == 5) || (i == 6);
            bt = '0;
            if (q.size() > 0) bt = q[0];
            drive(rst, !rst && (q.size() > 0), bt);
            n_vec += 3;
            if (s_if.in_ready !== exp_ready) begin
                n_err++; $display("[TB] FAIL rstmid.ready cyc=%0d got=%b exp=%b", k, s_if.in_ready, exp_ready);
            end
            if (got_l !== exp_l) begin
                n_err++; $display("[TB] FAIL rstmid.lanes cyc=%0d got=%h exp=%h", k, got_l, exp_l);
            end
            if ({y_valid, exp_yv ? y_data : 8'h00} !== {exp_yv, exp_yd}) begin
                n_err++; $display("[TB] FAIL rstmid.result cyc=%0d got=%b/%0d exp=%b/%0d", k, y_valid, y_data, exp_yv, exp_yd);
            end
            if (i == 4) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++; $display("[TB] FAIL rstmid.busy cyc=%0d got=%b exp=1", k, busy);
                end
            end
            if (y_valid === 1'b1) begin pulses++; last_y = y_data; end
            if (exp_ready && cur_v) void'(q.pop_front());
            advance();
        end
        n_vec += 2;
        if (pulses != 1) begin
            n_err++; $display("[TB] FAIL rstmid.pulses got=%0d exp=1", pulses);
        end
        if (last_y !== 8'd39) begin
            n_err++; $display("[TB] FAIL rstmid.value got=%0d exp=39", last_y);
        end
    endtask

    task automatic test_random();
        beat_t q[$];
        beat_t bt;
        int pulses = 0;
        int drain = 0;
        for (int i = 0; i < 75; i++) q.push_back(mk($urandom_range(255), $urandom_range(255), $urandom_range(255)));
        for (int i = 0; i < 600 && drain < 12; i++) begin
            bt = '0;
            if (q.size() > 0) bt = q[0];
            drive(1'b0, (q.size() > 0) && ($urandom_range(3) != 0), bt);
            n_vec += 3;
            if (s_if.in_ready !== exp_ready) begin
                n_err++; $display("[TB] FAIL random.ready cyc=%0d got=%b exp=%b", k, s_if.in_ready, exp_ready);
            end
            if (got_l !== exp_l) begin
                n_err++; $display("[TB] FAIL random.lanes cyc=%0d got=%h exp=%h", k, got_l, exp_l);
            end
            if ({y_valid, exp_yv ? y_data : 8'h00} !== {exp_yv, exp_yd}) begin
                n_err++; $display("[TB] FAIL random.result cyc=%0d got=%b/%0d exp=%b/%0d", k, y_valid, y_data, exp_yv, exp_yd);
            end
            if (y_valid === 1'b1) pulses++;
            if (exp_ready && cur_v) void'(q.pop_front());
            if (q.size() == 0) drain++;
            advance();
        end
        n_vec += 2;
        if (q.size() != 0) begin
            n_err++; $display("[TB] FAIL random.timeout beats left got=%0d exp=0", q.size());
        end
        if (pulses != 25) begin
            n_err++; $display("[TB] FAIL random.pulses got=%0d exp=25", pulses);
        end
    endtask

    initial begin
        reset = 1'b1;
        s_if.in_valid = 1'b0;
        s_if.in_a = '0; s_if.in_b = '0; s_if.in_c = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
